data_mem_lsu: RTL and testbench
===============================

Name: data_mem_lsu

Overview:
Parametrised successor to the core's word-only data memory. It adds byte and halfword stores, sign- and zero-extended loads, and misalignment and out-of-range error reporting. Reads are registered with a configurable, fixed latency. Reset clears the memory one word per cycle instead of in a single cycle. The block sits between the execute/memory pipeline stage and the writeback mux, and accepts one request per cycle.

Parameters:
ADDR_W, 32, byte-address width of req_addr.
DEPTH, 1024, memory size in 32-bit words; must be a power of two, at least 4.
READ_LATENCY, 1, cycles from request acceptance to rsp_valid; legal values are 1 or 2 (2 adds an output register stage).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (0 while clearing)
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32 width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned (bits [7:0] for SB, [15:0] for SH)
rsp_valid  out  1  response valid, single-cycle pulse per accepted request
rsp_rdata  out  32  extended load data; 0 for stores and for errors
rsp_err  out  1  misaligned, out-of-range or illegal funct3; qualified by rsp_valid
init_busy  out  1  clear sequence in progress

Behaviour:
- Reset is synchronous and active-high on clk. While reset is high: req_ready=0, init_busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the clear counter is held at 0.
- Clear sequence: starts in the first cycle after reset deasserts. One word (index = counter) is written to 0 per cycle for DEPTH cycles. init_busy and !req_ready hold until the cycle after the last word (DEPTH-1) is cleared.
- FSM has two states:
  - CLEAR: counter increments each cycle; moves to RUN when counter==DEPTH-1.
  - RUN: normal operation.
  - Reset from any state returns to CLEAR with the counter at 0.
- Acceptance: a request is accepted when req_valid && req_ready. In RUN, req_ready is 1; there is no backpressure. A request with req_valid high during CLEAR is ignored, not queued.
- Word index is req_addr[$clog2(DEPTH)+1:2]. If any bit of req_addr above that range is nonzero, the request is out of range.
- Error conditions (request is not performed):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - Out-of-range address.
  - Any funct3 outside {000,001,010,100,101}.
  - Store with funct3 of 100 or 101.
- On an error: no memory write occurs, and the response is rsp_err=1, rsp_rdata=0.
- Stores: the memory write happens on the acceptance edge.
  - Byte enables: SB = 1<<addr[1:0], SH = 0011 or 1100 selected by addr[1], SW = 1111.
  - Data is replicated across byte lanes.
  - The response carries rsp_err=0 and rsp_rdata=0.
- Loads: the addressed word is read at acceptance.
  - The lane is selected by addr[1:0]; B/H are sign-extended and BU/HU are zero-extended to 32 bits.
- Latency and ordering: every accepted request, load or store, produces exactly one response READ_LATENCY cycles after acceptance. Responses stay in order. Back-to-back requests give back-to-back responses.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the updated data. No same-cycle hazard exists because only one request is accepted per cycle.
- Reset mid-operation: in-flight responses are dropped (rsp_valid=0 from the reset cycle onward), and memory is cleared again.
- Outputs are registered; rsp_rdata and rsp_err hold their last value when rsp_valid=0 except after reset (0).

Decomposition:
- Shared package data_mem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Byte-enable width constant (4).
  - Typedef for the response struct {valid, err, rdata}.
- One sub-module, data_mem_lsu_align: combinational block that computes byte enables, replicated write data, the load lane-extract/extend, and the misalign/illegal flag. The top level holds the array, the CLEAR/RUN FSM, the counter and the latency pipeline.

Test Plan:
- Reset, then wait, with DEPTH=16 -> init_busy=1 for exactly 16 cycles after reset falls, req_ready=1 on the 17th cycle; a LW of every word returns 0x00000000.
- SW 0x80FF7F01 @0x4, then LB/LBU/LH/LHU @0x4 and @0x7 -> 0x00000001, 0x00000001, 0x00007F01, 0x00007F01; @0x7 LB returns 0xFFFFFF80 and LBU returns 0x00000080.
- SB 0xAA @0x9 over a word holding 0x11223344 @0x8, then LW @0x8 the next cycle -> 0x1122AA44, returned READ_LATENCY cycles after acceptance.
- LH @0x3, LW @0x6, SW to an address above DEPTH*4, funct3=011 -> each gives rsp_err=1 and rsp_rdata=0; a following LW shows the memory unchanged.
- READ_LATENCY=2, 8 back-to-back mixed requests -> 8 consecutive rsp_valid pulses in order, the first arriving 2 cycles after the first acceptance.
- Reset asserted with 2 loads in flight -> no rsp_valid appears, and init_busy re-runs the full clear.

Source files
------------

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_pkg
//  Brief    : Shared funct3 codes, byte-lane width and response record for the
//             data memory load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package data_mem_pkg;

   // RV32 load/store width and signedness codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Number of byte lanes in one memory word
   localparam int BE_W = 4;

   // One response beat as it travels down the latency pipeline
   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu_align
//  Brief    : Combinational lane logic: store byte enables and lane-replicated
//             write data, load lane extract with sign/zero extension, and the
//             misaligned / illegal-funct3 flag.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_lsu_align
   import data_mem_pkg::*;
(
   input  logic            write,
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [31:0]     wdata,
   input  logic [31:0]     rword,
   output logic [BE_W-1:0] byte_en,
   output logic [31:0]     wdata_rep,
   output logic [31:0]     load_data,
   output logic            bad
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Pick the addressed byte and halfword out of the word just read
   always_comb begin
      w_byte = rword[{addr_lo, 3'b000} +: 8];
      w_half = addr_lo[1] ? rword[31:16] : rword[15:0];
   end

   // Decode the access width: lanes, data replication, extension, legality
   always_comb begin
      byte_en   = '0;
      wdata_rep = wdata;
      load_data = '0;
      bad       = 1'b0;
      case (funct3)
         F3_B: begin
            byte_en   = 4'b0001 << addr_lo;
            wdata_rep = {4{wdata[7:0]}};
            load_data = {{24{w_byte[7]}}, w_byte};
         end
         F3_H: begin
            bad       = addr_lo[0];
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            load_data = {{16{w_half[15]}}, w_half};
         end
         F3_W: begin
            bad       = (addr_lo != 2'b00);
            byte_en   = 4'b1111;
            load_data = rword;
         end
         // Unsigned codes exist only for loads; a store using them is illegal
         F3_BU: begin
            bad       = write;
            load_data = {24'h0, w_byte};
         end
         F3_HU: begin
            bad       = write | addr_lo[0];
            load_data = {16'h0, w_half};
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         byte_en = '0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_lsu
//  Brief    : Byte-addressable data memory with B/H/W stores, signed and
//             unsigned loads, error reporting, a word-per-cycle clear after
//             reset and a fixed 1- or 2-cycle response latency.
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_lsu
   import data_mem_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DEPTH        = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              init_busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_count;
   logic [31:0]      r_mem [DEPTH];

   logic             w_accept;
   logic             w_oor;
   logic             w_bad;
   logic             w_err;
   logic             w_we;
   logic [IDX_W-1:0] w_idx;
   logic [31:0]      w_rword;
   logic [31:0]      w_wdata_rep;
   logic [31:0]      w_load_data;
   logic [BE_W-1:0]  w_be;
   rsp_t             w_stage_in;
   rsp_t             w_final_in;
   rsp_t             r_rsp;

   // Reset gates the handshake immediately so nothing slips in on a reset edge
   assign req_ready = (r_state == S_RUN) && !reset;
   assign init_busy = (r_state == S_CLEAR) || reset;
   assign w_accept  = req_valid && req_ready;

   assign w_idx   = req_addr[IDX_W+1:2];
   assign w_rword = r_mem[w_idx];

   // Any address bit above the word index means the access misses the array
   generate
      if (ADDR_W > IDX_W + 2) begin : g_oor
         assign w_oor = |req_addr[ADDR_W-1:IDX_W+2];
      end else begin : g_no_oor
         assign w_oor = 1'b0;
      end
   endgenerate

   data_mem_lsu_align u_align (
      .write     (req_write),
      .funct3    (req_funct3),
      .addr_lo   (req_addr[1:0]),
      .wdata     (req_wdata),
      .rword     (w_rword),
      .byte_en   (w_be),
      .wdata_rep (w_wdata_rep),
      .load_data (w_load_data),
      .bad       (w_bad)
   );

   assign w_err = w_oor | w_bad;
   assign w_we  = w_accept & req_write & ~w_err;

   // Response as formed at acceptance: stores and errors return zero data
   always_comb begin
      w_stage_in       = '0;
      w_stage_in.valid = w_accept;
      w_stage_in.err   = w_err;
      w_stage_in.rdata = (req_write || w_err) ? 32'h0 : w_load_data;
   end

   // CLEAR walks every word once, then RUN serves requests until next reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_CLEAR;
         r_count <= '0;
      end else begin
         case (r_state)
            S_CLEAR: begin
               r_count <= r_count + 1'b1;
               if (r_count == LAST_IDX) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN:   r_state <= S_RUN;
            default: r_state <= S_CLEAR;
         endcase
      end
   end

   // Memory array: clearing writes have priority, stores never overlap them
   always_ff @(posedge clk) begin
      if (!reset && r_state == S_CLEAR) begin
         r_mem[r_count] <= '0;
      end else if (w_we) begin
         for (int b = 0; b < BE_W; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
         end
      end
   end

   // Optional extra stage for the 2-cycle latency configuration
   generate
      if (READ_LATENCY == 2) begin : g_lat2
         rsp_t r_stage;
         // Intermediate response register; reset drops anything in flight
         always_ff @(posedge clk) begin
            if (reset) begin
               r_stage <= '0;
            end else begin
               r_stage <= w_stage_in;
            end
         end
         assign w_final_in = r_stage;
      end else begin : g_lat1
         assign w_final_in = w_stage_in;
      end
   endgenerate

   // Output register: valid pulses, data and error hold between responses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp <= '0;
      end else begin
         r_rsp.valid <= w_final_in.valid;
         if (w_final_in.valid) begin
            r_rsp.err   <= w_final_in.err;
            r_rsp.rdata <= w_final_in.rdata;
         end
      end
   end

   assign rsp_valid = r_rsp.valid;
   assign rsp_err   = r_rsp.err;
   assign rsp_rdata = r_rsp.rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_lsu
//  Brief    : Directed self-checking bench. Two instances (latency 1 and 2,
//             DEPTH 16) share one request stream; each request's response is
//             captured at its exact expected cycle and compared per test.
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_lsu;
   import data_mem_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DEPTH  = 16;
   localparam int MAXN   = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_write = 1'b0;
   logic [2:0]        req_funct3 = 3'b000;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;

   logic        req_ready1, rsp_valid1, rsp_err1, init_busy1;
   logic [31:0] rsp_rdata1;
   logic        req_ready2, rsp_valid2, rsp_err2, init_busy2;
   logic [31:0] rsp_rdata2;

   int checks = 0;
   int errors = 0;

   // Request batch and its expected responses
   int          n;
   logic        b_write [MAXN];
   logic [2:0]  b_f3    [MAXN];
   logic [31:0] b_addr  [MAXN];
   logic [31:0] b_wd    [MAXN];
   logic [31:0] e_d     [MAXN];
   logic        e_e     [MAXN];
   // Captured responses per instance
   logic        c1_v [MAXN];
   logic        c1_e [MAXN];
   logic [31:0] c1_d [MAXN];
   logic        c2_v [MAXN];
   logic        c2_e [MAXN];
   logic [31:0] c2_d [MAXN];
   int          extra1, extra2;

   always #5 clk = ~clk;

   data_mem_lsu #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
      .rsp_err(rsp_err1), .init_busy(init_busy1)
   );

   data_mem_lsu #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready2),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
      .rsp_err(rsp_err2), .init_busy(init_busy2)
   );

   task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] ed, input logic ee);
      b_write[n] = w; b_f3[n] = f3; b_addr[n] = a; b_wd[n] = wd;
      e_d[n] = ed; e_e[n] = ee;
      n++;
   endtask

   task automatic idle();
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
      req_addr = '0; req_wdata = '0;
   endtask

   // Drive the batch on consecutive cycles; grab each response at its due cycle
   task automatic run_batch();
      extra1 = 0; extra2 = 0;
      for (int c = 0; c <= n + 2; c++) begin
         @(negedge clk);
         if (c >= 1 && c - 1 < n) begin
            c1_v[c-1] = rsp_valid1; c1_d[c-1] = rsp_rdata1; c1_e[c-1] = rsp_err1;
         end else if (rsp_valid1) extra1++;
         if (c >= 2 && c - 2 < n) begin
            c2_v[c-2] = rsp_valid2; c2_d[c-2] = rsp_rdata2; c2_e[c-2] = rsp_err2;
         end else if (rsp_valid2) extra2++;
         if (c < n) begin
            req_valid = 1'b1; req_write = b_write[c]; req_funct3 = b_f3[c];
            req_addr = b_addr[c]; req_wdata = b_wd[c];
         end else idle();
      end
   endtask

   // Release reset with a load held on req_valid; count busy cycles
   task automatic release_reset(output int busy1, output int busy2,
                                output int spur, output logic done_ok);
      busy1 = 0; busy2 = 0; spur = 0;
      @(negedge clk);
      reset = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h4;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         if (init_busy1 && !req_ready1) busy1++;
         if (init_busy2 && !req_ready2) busy2++;
         if (rsp_valid1 || rsp_valid2) spur++;
         @(negedge clk);
      end
      idle();
      #1;
      done_ok = !init_busy1 && req_ready1 && !init_busy2 && req_ready2;
   endtask

   task automatic test_reset();
      int   bz1, bz2, sp;
      logic ok;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid1 !== 1'b0 || rsp_rdata1 !== 32'h0 || rsp_err1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp lat1: got v=%b d=%h e=%b, want 0/00000000/0", rsp_valid1, rsp_rdata1, rsp_err1);
      end
      checks++;
      if (rsp_valid2 !== 1'b0 || rsp_rdata2 !== 32'h0 || rsp_err2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp lat2: got v=%b d=%h e=%b, want 0/00000000/0", rsp_valid2, rsp_rdata2, rsp_err2);
      end
      checks++;
      if (req_ready1 !== 1'b0 || init_busy1 !== 1'b1 || req_ready2 !== 1'b0 || init_busy2 !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: got ready=%b/%b busy=%b/%b, want ready=0 busy=1", req_ready1, req_ready2, init_busy1, init_busy2);
      end
      release_reset(bz1, bz2, sp, ok);
      checks++;
      if (bz1 != DEPTH || bz2 != DEPTH) begin
         errors++;
         $display("FAIL clear_len: got busy cycles %0d/%0d, want %0d", bz1, bz2, DEPTH);
      end
      checks++;
      if (sp != 0) begin
         errors++;
         $display("FAIL clear_ignore: got %0d responses during clear, want 0", sp);
      end
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL clear_done: got done=%b after %0d cycles, want 1", ok, DEPTH);
      end
      n = 0;
      for (int k = 0; k < DEPTH; k++) add(1'b0, F3_W, 32'(4 * k), 32'h0, 32'h0, 1'b0);
      run_batch();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (c1_v[k] !== 1'b1 || c1_d[k] !== e_d[k] || c1_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL zero_word[%0d] lat1: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c1_v[k], c1_d[k], c1_e[k], e_d[k], e_e[k]);
         end
         checks++;
         if (c2_v[k] !== 1'b1 || c2_d[k] !== e_d[k] || c2_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL zero_word[%0d] lat2: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c2_v[k], c2_d[k], c2_e[k], e_d[k], e_e[k]);
         end
      end
      checks++;
      if (extra1 != 0 || extra2 != 0) begin
         errors++;
         $display("FAIL zero_extra: got %0d/%0d stray pulses, want 0", extra1, extra2);
      end
   endtask

   task automatic test_extend();
      n = 0;
      add(1'b1, F3_W,  32'h4, 32'h80FF7F01, 32'h00000000, 1'b0);
      add(1'b0, F3_B,  32'h4, 32'h0,        32'h00000001, 1'b0);
      add(1'b0, F3_BU, 32'h4, 32'h0,        32'h00000001, 1'b0);
      add(1'b0, F3_H,  32'h4, 32'h0,        32'h00007F01, 1'b0);
      add(1'b0, F3_HU, 32'h4, 32'h0,        32'h00007F01, 1'b0);
      add(1'b0, F3_B,  32'h7, 32'h0,        32'hFFFFFF80, 1'b0);
      add(1'b0, F3_BU, 32'h7, 32'h0,        32'h00000080, 1'b0);
      add(1'b0, F3_H,  32'h6, 32'h0,        32'hFFFF80FF, 1'b0);
      add(1'b0, F3_HU, 32'h6, 32'h0,        32'h000080FF, 1'b0);
      add(1'b0, F3_B,  32'h5, 32'h0,        32'h0000007F, 1'b0);
      run_batch();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (c1_v[k] !== 1'b1 || c1_d[k] !== e_d[k] || c1_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL extend[%0d] lat1: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c1_v[k], c1_d[k], c1_e[k], e_d[k], e_e[k]);
         end
         checks++;
         if (c2_v[k] !== 1'b1 || c2_d[k] !== e_d[k] || c2_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL extend[%0d] lat2: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c2_v[k], c2_d[k], c2_e[k], e_d[k], e_e[k]);
         end
      end
      checks++;
      if (extra1 != 0 || extra2 != 0) begin
         errors++;
         $display("FAIL extend_extra: got %0d/%0d stray pulses, want 0", extra1, extra2);
      end
   endtask

   task automatic test_raw();
      n = 0;
      add(1'b1, F3_W, 32'h8, 32'h11223344, 32'h0, 1'b0);
      add(1'b1, F3_B, 32'h9, 32'hDEADBEAA, 32'h0, 1'b0);
      add(1'b0, F3_W, 32'h8, 32'h0, 32'h1122AA44, 1'b0);
      run_batch();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (c1_v[k] !== 1'b1 || c1_d[k] !== e_d[k] || c1_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL raw[%0d] lat1: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c1_v[k], c1_d[k], c1_e[k], e_d[k], e_e[k]);
         end
         checks++;
         if (c2_v[k] !== 1'b1 || c2_d[k] !== e_d[k] || c2_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL raw[%0d] lat2: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c2_v[k], c2_d[k], c2_e[k], e_d[k], e_e[k]);
         end
      end
      checks++;
      if (extra1 != 0 || extra2 != 0) begin
         errors++;
         $display("FAIL raw_extra: got %0d/%0d stray pulses, want 0", extra1, extra2);
      end
   endtask

   task automatic test_errors();
      n = 0;
      add(1'b0, F3_H,   32'h3,        32'h0,        32'h0, 1'b1);
      add(1'b0, F3_W,   32'h6,        32'h0,        32'h0, 1'b1);
      add(1'b1, F3_W,   32'h48,       32'hFFFFFFFF, 32'h0, 1'b1);
      add(1'b0, 3'b011, 32'h8,        32'h0,        32'h0, 1'b1);
      add(1'b1, F3_BU,  32'h8,        32'hFFFFFFFF, 32'h0, 1'b1);
      add(1'b1, F3_H,   32'h9,        32'hFFFFFFFF, 32'h0, 1'b1);
      add(1'b1, F3_W,   32'h80000008, 32'hFFFFFFFF, 32'h0, 1'b1);
      add(1'b0, F3_W,   32'h8,        32'h0, 32'h1122AA44, 1'b0);
      add(1'b0, F3_W,   32'h0,        32'h0, 32'h00000000, 1'b0);
      add(1'b0, F3_W,   32'h4,        32'h0, 32'h80FF7F01, 1'b0);
      run_batch();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (c1_v[k] !== 1'b1 || c1_d[k] !== e_d[k] || c1_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL error[%0d] lat1: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c1_v[k], c1_d[k], c1_e[k], e_d[k], e_e[k]);
         end
         checks++;
         if (c2_v[k] !== 1'b1 || c2_d[k] !== e_d[k] || c2_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL error[%0d] lat2: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c2_v[k], c2_d[k], c2_e[k], e_d[k], e_e[k]);
         end
      end
      checks++;
      if (extra1 != 0 || extra2 != 0) begin
         errors++;
         $display("FAIL error_extra: got %0d/%0d stray pulses, want 0", extra1, extra2);
      end
   endtask

   task automatic test_back_to_back();
      n = 0;
      add(1'b1, F3_W,  32'hC, 32'hCAFEBABE, 32'h0,        1'b0);
      add(1'b0, F3_W,  32'hC, 32'h0,        32'hCAFEBABE, 1'b0);
      add(1'b1, F3_H,  32'hE, 32'hFFFF1234, 32'h0,        1'b0);
      add(1'b0, F3_HU, 32'hE, 32'h0,        32'h00001234, 1'b0);
      add(1'b0, F3_W,  32'hC, 32'h0,        32'h1234BABE, 1'b0);
      add(1'b1, F3_B,  32'hC, 32'h00000055, 32'h0,        1'b0);
      add(1'b0, F3_B,  32'hC, 32'h0,        32'h00000055, 1'b0);
      add(1'b0, F3_W,  32'hC, 32'h0,        32'h1234BA55, 1'b0);
      run_batch();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (c1_v[k] !== 1'b1 || c1_d[k] !== e_d[k] || c1_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL b2b[%0d] lat1: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c1_v[k], c1_d[k], c1_e[k], e_d[k], e_e[k]);
         end
         checks++;
         if (c2_v[k] !== 1'b1 || c2_d[k] !== e_d[k] || c2_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL b2b[%0d] lat2: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c2_v[k], c2_d[k], c2_e[k], e_d[k], e_e[k]);
         end
      end
      checks++;
      if (extra1 != 0 || extra2 != 0) begin
         errors++;
         $display("FAIL b2b_extra: got %0d/%0d stray pulses, want 0", extra1, extra2);
      end
   endtask

   task automatic test_reset_midop();
      int   bz1, bz2, sp, bad;
      logic ok;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = F3_W; req_addr = 32'h4;
      @(negedge clk);
      req_addr = 32'h8;
      @(negedge clk);
      reset = 1'b1;
      idle();
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid1 || rsp_valid2 || rsp_rdata1 != 32'h0 || rsp_rdata2 != 32'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midop_drop: got %0d cycles with response activity in reset, want 0", bad);
      end
      release_reset(bz1, bz2, sp, ok);
      checks++;
      if (bz1 != DEPTH || bz2 != DEPTH || sp != 0 || ok !== 1'b1) begin
         errors++;
         $display("FAIL midop_clear: got busy=%0d/%0d stray=%0d done=%b, want %0d/%0d 0 1", bz1, bz2, sp, ok, DEPTH, DEPTH);
      end
      n = 0;
      add(1'b0, F3_W, 32'h4, 32'h0, 32'h0, 1'b0);
      add(1'b0, F3_W, 32'h8, 32'h0, 32'h0, 1'b0);
      add(1'b0, F3_W, 32'hC, 32'h0, 32'h0, 1'b0);
      run_batch();
      for (int k = 0; k < n; k++) begin
         checks++;
         if (c1_v[k] !== 1'b1 || c1_d[k] !== e_d[k] || c1_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL midop_word[%0d] lat1: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c1_v[k], c1_d[k], c1_e[k], e_d[k], e_e[k]);
         end
         checks++;
         if (c2_v[k] !== 1'b1 || c2_d[k] !== e_d[k] || c2_e[k] !== e_e[k]) begin
            errors++;
            $display("FAIL midop_word[%0d] lat2: got v=%b d=%h e=%b, want v=1 d=%h e=%b", k, c2_v[k], c2_d[k], c2_e[k], e_d[k], e_e[k]);
         end
      end
      checks++;
      if (extra1 != 0 || extra2 != 0) begin
         errors++;
         $display("FAIL midop_extra: got %0d/%0d stray pulses, want 0", extra1, extra2);
      end
   endtask

   initial begin
      test_reset();
      test_extend();
      test_raw();
      test_errors();
      test_back_to_back();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case the run stalls
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000ns, want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
